// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   ADDR_W / INST_W   : address and instruction bus widths
//   RESET_PC_DEFAULT  : PC loaded on reset unless overridden
//   if_state_e        : fetch FSM encoding (S_FETCH / S_HOLD)
//   next_pc()         : sequential PC increment, wraps modulo 2^32
package if_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } if_state_e;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage, the memory controller fetch port and
// the decode stage.
//   mc_if_enable/mc_if_addr           : fetch request (fetch stage -> controller)
//   mc_if_inst/mc_if_busy/finished    : fetch response (controller -> fetch stage)
//   id_valid/id_pc/id_inst            : presented instruction (fetch stage -> decode)
// modport master: the fetch stage; modport slave: controller/decode side.
interface if_stage_if;
  import if_stage_pkg::*;

  logic              mc_if_enable;
  logic [ADDR_W-1:0] mc_if_addr;
  logic [INST_W-1:0] mc_if_inst;
  logic              mc_if_busy;
  logic              mc_if_finished;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output mc_if_enable, mc_if_addr, id_valid, id_pc, id_inst,
    input  mc_if_inst, mc_if_busy, mc_if_finished
  );

  modport slave (
    input  mc_if_enable, mc_if_addr, id_valid, id_pc, id_inst,
    output mc_if_inst, mc_if_busy, mc_if_finished
  );

endinterface

// File: rtl/if_stage_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Only compiled when ICACHE_EN is defined.
//   clk, rst     : clock, synchronous active-high reset (clears valid bits)
//   addr_i       : lookup and fill address (current PC)
//   fill_en_i    : write fill_data_i into the line selected by addr_i
//   fill_data_i  : word returned by the memory controller
//   hit_o        : line valid and tag matches addr_i
//   hit_data_o   : cached word for addr_i
`ifdef ICACHE_EN
module icache_dm
  import if_stage_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              fill_en_i,
  input  logic [INST_W-1:0] fill_data_i,
  output logic              hit_o,
  output logic [INST_W-1:0] hit_data_o
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;

  assign idx = addr_i[IDX_W+1:2];
  assign tag = addr_i[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^addr_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_data_i;
    end
  end

  assign hit_o      = valid_q[idx] && (tag_q[idx] == tag);
  assign hit_data_o = data_q[idx];

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, drives the memory controller fetch
// port and presents {pc, inst, valid} to decode through a stallable register.
// Optional I-cache is built when the macro ICACHE_EN is defined.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   rdy                : global ready; low freezes every register
//   stall_i            : decode not accepting; presented instruction must hold
//   branch_flag_i      : one-cycle redirect request from EX
//   branch_target_i    : redirect PC
//   fetch_if (master)  : controller fetch port and decode-facing outputs
//
// state   | meaning
// S_FETCH | request outstanding at pc_q (or cache lookup in progress)
// S_HOLD  | word parked in hold buffer, bus released, waiting for decode
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int                ICACHE_IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  if_stage_if.master        fetch_if
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;

  logic              cache_hit;
  logic [INST_W-1:0] cache_word;
  logic              accept;
  logic              fetch_done;
  logic [INST_W-1:0] word;
  logic              unused_busy;

  assign unused_busy = fetch_if.mc_if_busy;

`ifdef ICACHE_EN
  logic cache_fill;

  // Completions arriving with a redirect are dropped, so they never reach the cache.
  assign cache_fill = rdy && (state_q == S_FETCH) && fetch_if.mc_if_finished
                      && !cache_hit && !branch_flag_i;

  icache_dm #(
    .IDX_W(ICACHE_IDX_W)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (pc_q),
    .fill_en_i  (cache_fill),
    .fill_data_i(fetch_if.mc_if_inst),
    .hit_o      (cache_hit),
    .hit_data_o (cache_word)
  );
`else
  localparam int unused_icache_idx_w = ICACHE_IDX_W;
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  assign accept     = !stall_i || !id_valid_q;
  assign fetch_done = (state_q == S_FETCH) && (cache_hit || fetch_if.mc_if_finished);
  // A hit means no request is outstanding, so any finished pulse then is stale.
  assign word       = cache_hit ? cache_word : fetch_if.mc_if_inst;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    if (branch_flag_i) begin
      pc_d       = branch_target_i;
      id_valid_d = 1'b0;
      state_d    = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (fetch_done) begin
            if (accept) begin
              id_valid_d = 1'b1;
              id_pc_d    = pc_q;
              id_inst_d  = word;
              pc_d       = next_pc(pc_q);
            end else begin
              buf_d    = word;
              buf_pc_d = pc_q;
              state_d  = S_HOLD;
            end
          end else if (accept) begin
            id_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (accept) begin
            id_valid_d = 1'b1;
            id_pc_d    = buf_pc_q;
            id_inst_d  = buf_q;
            pc_d       = next_pc(buf_pc_q);
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      buf_q      <= '0;
      buf_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  assign fetch_if.mc_if_enable = !rst && (state_q == S_FETCH) && !cache_hit;
  assign fetch_if.mc_if_addr   = pc_q;
  assign fetch_if.id_valid     = id_valid_q;
  assign fetch_if.id_pc        = id_pc_q;
  assign fetch_if.id_inst      = id_inst_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC    (32'h0),
    .ICACHE_IDX_W(6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .stall_i        (stall_i),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .fetch_if       (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory controller model knobs/state
  int          fixed_lat = 5;
  int          mc_cnt = 0;
  int          mc_lat = 1;
  bit          mc_fresh = 1'b1;
  logic [31:0] mc_last = 32'h0;
  logic [31:0] preempt_addr = 32'h0;
  int          preempt_n = 0;
  int          stretch = 0;
  bit          bof_en = 1'b0;
  logic [31:0] bof_addr = 32'h0;
  logic [31:0] bof_tgt = 32'h0;

  // program-order reference
  logic [31:0] exp_pc = 32'h0;
  int          consumed = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive controller response for the coming edge, then check at negedge.
  task automatic cycle();
    logic        p_valid, p_en;
    logic [31:0] p_pc, p_inst, p_addr;
    #1;
    bus.mc_if_finished = 1'b0;
    if (rst || bus.mc_if_enable !== 1'b1) begin
      mc_cnt   = 0;
      mc_fresh = 1'b1;
    end else if (rdy) begin
      if (mc_fresh || bus.mc_if_addr !== mc_last) begin
        mc_fresh = 1'b0;
        mc_last  = bus.mc_if_addr;
        mc_cnt   = 0;
        mc_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        if (preempt_n > 0 && bus.mc_if_addr == preempt_addr) begin
          mc_lat   += preempt_n;
          preempt_n = 0;
        end
      end
      if (stretch > 0) stretch--;
      else begin
        mc_cnt++;
        if (mc_cnt >= mc_lat) begin
          bus.mc_if_finished = 1'b1;
          bus.mc_if_inst     = ref_word(bus.mc_if_addr);
          mc_cnt             = 0;
          if (bof_en && bus.mc_if_addr == bof_addr) begin
            branch_flag_i   = 1'b1;
            branch_target_i = bof_tgt;
            bof_en          = 1'b0;
          end
        end
      end
    end
    bus.mc_if_busy = bus.mc_if_enable && rdy;
    p_valid = bus.id_valid;
    p_pc    = bus.id_pc;
    p_inst  = bus.id_inst;
    p_addr  = bus.mc_if_addr;
    p_en    = bus.mc_if_enable;
    @(negedge clk);
    if (rst) begin
      exp_pc = 32'h0;
    end else if (!rdy) begin
      chk("frz valid", 32'(bus.id_valid), 32'(p_valid));
      chk("frz pc", bus.id_pc, p_pc);
      chk("frz inst", bus.id_inst, p_inst);
      chk("frz addr", bus.mc_if_addr, p_addr);
    end else begin
      if (p_valid && !stall_i) begin
        chk("seq pc", p_pc, exp_pc);
        chk("seq inst", p_inst, ref_word(p_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (branch_flag_i) begin
        exp_pc = branch_target_i;
        chk("br squash", 32'(bus.id_valid), 32'd0);
      end else begin
        if (p_valid && stall_i) begin
          chk("stall valid", 32'(bus.id_valid), 32'd1);
          chk("stall pc", bus.id_pc, p_pc);
          chk("stall inst", bus.id_inst, p_inst);
        end
        if (p_en && !bus.mc_if_finished) chk("addr stable", bus.mc_if_addr, p_addr);
      end
    end
    branch_flag_i = 1'b0;
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] pc, input int maxc, output int n);
    n = 0;
    while (!(bus.id_valid === 1'b1 && bus.id_pc === pc) && n < maxc) begin
      cycle();
      n++;
    end
    chk(tag, 32'(bus.id_valid === 1'b1 && bus.id_pc === pc), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [31:0] s_pc, s_addr;
    logic        s_valid;

    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0;
    branch_flag_i = 1'b0; branch_target_i = 32'h0;
    bus.mc_if_inst = 32'h0; bus.mc_if_busy = 1'b0; bus.mc_if_finished = 1'b0;

    // reset state
    cycle(); cycle();
    chk("rst enable", 32'(bus.mc_if_enable), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst valid", 32'(bus.id_valid), 32'd0);
    chk("rst id_pc", bus.id_pc, 32'h0);
    chk("rst id_inst", bus.id_inst, 32'h0);
    chk("rst addr", bus.mc_if_addr, 32'h0);
    chk("rst req", 32'(bus.mc_if_enable), 32'd1);

    // 1: first fetch after 5-cycle controller latency
    wait_pc("t1 reached", 32'h0, 20, n);
    chk("t1 inst", bus.id_inst, 32'h0000_0013);
    chk("t1 next addr", bus.mc_if_addr, 32'h4);

    // 2: stall while 0x8 completes
    wait_pc("t2 pre", 32'h4, 20, n);
    stall_i = 1'b1;
    n = 0;
    while (bus.mc_if_enable === 1'b1 && n < 20) begin cycle(); n++; end
    chk("t2 enable drop", 32'(bus.mc_if_enable), 32'd0);
    chk("t2 frozen pc", bus.id_pc, 32'h4);
    cycle();
    chk("t2 still idle", 32'(bus.mc_if_enable), 32'd0);
    stall_i = 1'b0;
    cycle();
    chk("t2 release pc", bus.id_pc, 32'h8);
    chk("t2 release valid", 32'(bus.id_valid), 32'd1);
    chk("t2 resume addr", bus.mc_if_addr, 32'hC);
    chk("t2 resume req", 32'(bus.mc_if_enable), 32'd1);

    // 3: branch in the same cycle as completion for 0x10
    bof_en = 1'b1; bof_addr = 32'h10; bof_tgt = 32'h100;
    n = 0;
    while (bof_en && n < 30) begin cycle(); n++; end
    chk("t3 fired", 32'(bof_en), 32'd0);
    chk("t3 valid", 32'(bus.id_valid), 32'd0);
    chk("t3 addr", bus.mc_if_addr, 32'h100);
    wait_pc("t3 target", 32'h100, 20, n);
    chk("t3 inst", bus.id_inst, ref_word(32'h100));

    // 4: fetch at 0x20 preempted by a data access for 6 cycles
    preempt_addr = 32'h20; preempt_n = 6;
    branch_flag_i = 1'b1; branch_target_i = 32'h20;
    cycle();
    chk("t4 addr", bus.mc_if_addr, 32'h20);
    wait_pc("t4 reached", 32'h20, 30, n);
    chk("t4 latency", 32'(n), 32'd11);
    cycle();
    chk("t4 no dup", 32'(bus.id_valid), 32'd0);

    // 5: rdy low for 3 cycles mid-fetch
    cycle();
    s_valid = bus.id_valid; s_pc = bus.id_pc; s_addr = bus.mc_if_addr;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5 hold addr", bus.mc_if_addr, s_addr);
      chk("t5 hold valid", 32'(bus.id_valid), 32'(s_valid));
      chk("t5 hold pc", bus.id_pc, s_pc);
    end
    rdy = 1'b1;
    wait_pc("t5 resume", 32'h24, 20, n);
    wait_pc("t5 next", 32'h28, 20, n);

`ifdef ICACHE_EN
    // 6: loop 0x0..0xC twice; second pass served by the cache
    fixed_lat = 2;
    branch_flag_i = 1'b1; branch_target_i = 32'h0;
    cycle();
    wait_pc("t6 pass1", 32'hC, 40, n);
    branch_flag_i = 1'b1; branch_target_i = 32'h0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("t6 no req", 32'(bus.mc_if_enable), 32'd0);
      cycle();
      chk("t6 hit valid", 32'(bus.id_valid), 32'd1);
      chk("t6 hit pc", bus.id_pc, 32'(i * 4));
    end
`endif

    // randomized traffic against the program-order model
    fixed_lat = 0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      rdy     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) stretch = $urandom_range(1, 6);
      if ($urandom_range(0, 29) == 0) begin
        branch_flag_i = 1'b1;
        case ($urandom_range(0, 3))
          0: branch_target_i = $urandom();
          1: branch_target_i = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
          2: branch_target_i = 32'($urandom_range(0, 63)) << 2;
          default: branch_target_i = $urandom() & 32'hFFFF_FFFC;
        endcase
      end
      cycle();
    end
    stall_i = 1'b0; rdy = 1'b1;
    chk("rand progress", 32'(consumed > 100), 32'd1);

    // reset in the middle of a fetch
    fixed_lat = 5;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("mrst addr", bus.mc_if_addr, 32'h0);
    chk("mrst valid", 32'(bus.id_valid), 32'd0);
    wait_pc("mrst refetch", 32'h0, 20, n);
    chk("mrst inst", bus.id_inst, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
